// File: rtl/mem_responder.sv
// Word-addressed memory responder with request/response handshakes
// and a programmable number of wait states before each access.
module mem_responder #(
  parameter int          DEPTH     = 256,
  parameter int          LATENCY   = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        resetN,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqWrite,
  input  logic [31:0] reqAddr,
  input  logic [31:0] reqWData,
  output logic        rspValid,
  input  logic        rspReady,
  output logic [31:0] rspRData,
  output logic        rspError
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
  localparam logic [CW-1:0] LAT = CW'(LATENCY);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WAIT    = 2'd1;
  localparam logic [1:0] COMMIT  = 2'd2;
  localparam logic [1:0] RESPOND = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          wr_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;

  logic [31:0]   mem [DEPTH];

  logic [31:0]   off;
  logic          err;
  logic [AW-1:0] idx;

  // Offset bits above the array span flag out-of-range addresses.
  assign off = addr_q - BASE_ADDR;
  assign err = (|off[1:0])
             | (addr_q < BASE_ADDR)
             | (|off[31:AW+2]);
  assign idx = off[AW+1:2];

  assign reqReady = (state == IDLE);
  assign rspValid = (state == RESPOND);

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state    <= IDLE;
      cnt      <= '0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rspRData <= '0;
      rspError <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (reqValid) begin
            wr_q    <= reqWrite;
            addr_q  <= reqAddr;
            wdata_q <= reqWData;
            cnt     <= LAT;
            state   <= (LATENCY > 0) ? WAIT : COMMIT;
          end
        end
        WAIT: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= COMMIT;
        end
        COMMIT: begin
          if (err) begin
            rspRData <= '0;
            rspError <= 1'b1;
          end else if (wr_q) begin
            rspRData <= '0;
          end else begin
            rspRData <= mem[idx];
          end
          state <= RESPOND;
        end
        RESPOND: begin
          if (rspReady) begin
            rspRData <= '0;
            rspError <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Array has no reset; an aborted request never reaches COMMIT.
  always_ff @(posedge clock) begin
    if (state == COMMIT && wr_q && !err) mem[idx] <= wdata_q;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed table, reset abort, random
// traffic against an array model, and a zero-latency instance.
module tb_mem_responder;

  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic        clock = 1'b0;
  logic        resetN;
  logic        reqValid, reqReady, reqWrite;
  logic [31:0] reqAddr, reqWData;
  logic        rspValid, rspReady, rspError;
  logic [31:0] rspRData;

  logic        z_reqValid, z_reqReady, z_reqWrite;
  logic [31:0] z_reqAddr, z_reqWData;
  logic        z_rspValid, z_rspReady, z_rspError;
  logic [31:0] z_rspRData;

  always #5 clock = ~clock;

  mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clock(clock), .resetN(resetN),
    .reqValid(reqValid), .reqReady(reqReady),
    .reqWrite(reqWrite), .reqAddr(reqAddr),
    .reqWData(reqWData), .rspValid(rspValid),
    .rspReady(rspReady), .rspRData(rspRData),
    .rspError(rspError)
  );

  mem_responder #(.DEPTH(DEPTH), .LATENCY(0)) dut0 (
    .clock(clock), .resetN(resetN),
    .reqValid(z_reqValid), .reqReady(z_reqReady),
    .reqWrite(z_reqWrite), .reqAddr(z_reqAddr),
    .reqWData(z_reqWData), .rspValid(z_rspValid),
    .rspReady(z_rspReady), .rspRData(z_rspRData),
    .rspError(z_rspError)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] model [int];

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          stall;
    bit          exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl [12];

  function automatic void chk(string name, logic [31:0] act,
                              logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endfunction

  function automatic bit addr_err(logic [31:0] a);
    return (a % 4 != 0) || ((a / 4) >= DEPTH);
  endfunction

  task automatic run_req(input bit wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input int stall,
                         input bit ee, input logic [31:0] er,
                         input bit chk_data);
    int          cyc;
    logic [31:0] hold;
    bit          herr;
    chk("req_ready_idle", 32'(reqReady), 1);
    reqValid = 1'b1;
    reqWrite = wr;
    reqAddr  = addr;
    reqWData = wdata;
    rspReady = (stall == 0);
    @(posedge clock); #1;
    reqValid = 1'b0;
    reqAddr  = $urandom;
    reqWData = $urandom;
    cyc = 0;
    while (!rspValid && cyc < 20) begin
      @(posedge clock); #1;
      cyc++;
    end
    chk("latency", 32'(cyc), 32'(LAT + 1));
    if (rspValid) begin
      chk("rsp_error", 32'(rspError), 32'(ee));
      if (chk_data) chk("rsp_rdata", rspRData, er);
      hold = rspRData;
      herr = rspError;
      for (int i = 0; i < stall; i++) begin
        reqValid = 1'($urandom_range(0, 1));
        reqWrite = 1'($urandom_range(0, 1));
        @(posedge clock); #1;
        chk("stall_valid", 32'(rspValid), 1);
        chk("stall_rdata", rspRData, hold);
        chk("stall_error", 32'(rspError), 32'(herr));
        chk("stall_req_ready", 32'(reqReady), 0);
      end
      reqValid = 1'b0;
      rspReady = 1'b1;
      @(posedge clock); #1;
      chk("idle_rsp_valid", 32'(rspValid), 0);
      chk("idle_rdata", rspRData, 0);
      chk("idle_error", 32'(rspError), 0);
      chk("idle_req_ready", 32'(reqReady), 1);
    end
    if (wr && !addr_err(addr)) model[int'(addr >> 2)] = wdata;
  endtask

  initial begin
    tbl[0]  = '{1, 32'h10,  32'hDEAD_BEEF, 0, 0, 32'h0};
    tbl[1]  = '{0, 32'h10,  32'h0,         0, 0, 32'hDEAD_BEEF};
    tbl[2]  = '{1, 32'h20,  32'hA5A5_0020, 0, 0, 32'h0};
    tbl[3]  = '{0, 32'h13,  32'h0,         0, 1, 32'h0};
    tbl[4]  = '{1, 32'h22,  32'hFFFF_FFFF, 0, 1, 32'h0};
    tbl[5]  = '{0, 32'h20,  32'h0,         5, 0, 32'hA5A5_0020};
    tbl[6]  = '{0, 32'h400, 32'h0,         0, 1, 32'h0};
    tbl[7]  = '{1, 32'h3FC, 32'h0BAD_F00D, 0, 0, 32'h0};
    tbl[8]  = '{0, 32'h3FC, 32'h0,         2, 0, 32'h0BAD_F00D};
    tbl[9]  = '{1, 32'h8,   32'hCAFE_0008, 0, 0, 32'h0};
    tbl[10] = '{0, 32'h8,   32'h0,         0, 0, 32'hCAFE_0008};
    tbl[11] = '{1, 32'hFFFF_FFFC, 32'h1,   1, 1, 32'h0};

    resetN   = 1'b0;
    reqValid = 1'b0; reqWrite = 1'b0;
    reqAddr  = '0;   reqWData = '0;
    rspReady = 1'b1;
    z_reqValid = 1'b0; z_reqWrite = 1'b0;
    z_reqAddr  = '0;   z_reqWData = '0;
    z_rspReady = 1'b1;
    #1;
    chk("rst_req_ready", 32'(reqReady), 1);
    chk("rst_rsp_valid", 32'(rspValid), 0);
    chk("rst_rdata", rspRData, 0);
    chk("rst_error", 32'(rspError), 0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    resetN = 1'b1;
    @(posedge clock); #1;

    for (int i = 0; i < 12; i++)
      run_req(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].stall,
              tbl[i].exp_err, tbl[i].exp_rdata, 1'b1);

    // abort a write to 0x8 while it is still waiting
    reqValid = 1'b1; reqWrite = 1'b1;
    reqAddr  = 32'h8; reqWData = 32'h1234_5678;
    rspReady = 1'b1;
    @(posedge clock); #1;
    reqValid = 1'b0;
    chk("wait_req_ready", 32'(reqReady), 0);
    chk("wait_rsp_valid", 32'(rspValid), 0);
    #2;
    resetN = 1'b0;
    #1;
    chk("abort_req_ready", 32'(reqReady), 1);
    chk("abort_rsp_valid", 32'(rspValid), 0);
    chk("abort_rdata", rspRData, 0);
    chk("abort_error", 32'(rspError), 0);
    @(posedge clock);
    @(posedge clock); #1;
    resetN = 1'b1;
    @(posedge clock); #1;
    run_req(1'b0, 32'h8, 32'h0, 0, 1'b0, 32'hCAFE_0008, 1'b1);

    for (int n = 0; n < 150; n++) begin
      int          mode;
      int          idx;
      bit          wr;
      logic [31:0] a;
      logic [31:0] d;
      bit          ee;
      logic [31:0] er;
      bit          known;
      mode = $urandom_range(0, 9);
      idx  = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 15)
                                         : $urandom_range(248, 255);
      if (mode <= 6)      a = 32'(idx * 4);
      else if (mode == 7) a = 32'(idx * 4 + $urandom_range(1, 3));
      else                a = 32'($urandom_range(256, 100000) * 4);
      wr = 1'($urandom_range(0, 1));
      d  = $urandom;
      ee = addr_err(a);
      known = 1'b1;
      er = 32'h0;
      if (!wr && !ee) begin
        if (model.exists(int'(a >> 2))) er = model[int'(a >> 2)];
        else known = 1'b0;
      end
      run_req(wr, a, d, $urandom_range(0, 3), ee, er, known);
    end

    // zero-latency instance, back-to-back with rspValid accepted
    chk("z_req_ready_idle", 32'(z_reqReady), 1);
    z_reqValid = 1'b1; z_reqWrite = 1'b1;
    z_reqAddr  = 32'h0; z_reqWData = 32'h1111_1111;
    z_rspReady = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clock); #1;
      if (k == 1) z_reqWrite = 1'b0;
      chk("z_rsp_valid", 32'(z_rspValid), 32'(k % 3 == 2));
      chk("z_req_ready", 32'(z_reqReady), 32'(k % 3 == 0));
      if (k % 3 == 2) begin
        chk("z_rdata", z_rspRData,
            (k == 2) ? 32'h0 : 32'h1111_1111);
        chk("z_error", 32'(z_rspError), 0);
      end
    end
    z_reqValid = 1'b0;
    @(posedge clock); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
